// File: rtl/pipelined_instruction_decoder_pkg.sv
// Shared types and constants for the instruction decode stage (package decoder_pkg).
// The LEGAL_OPCODES table is only consulted when DECODER_ILLEGAL_OP_EN is defined.
package decoder_pkg;

    localparam int DEC_INSTR_W = 32;
    localparam int DEC_OPC_W   = 6;
    localparam int DEC_REG_W   = 5;
    localparam int DEC_FUNC_W  = 5;
    localparam int DEC_IMM_W   = 16;

    typedef enum logic [1:0] {
        CLS_R = 2'd0,
        CLS_I = 2'd1,
        CLS_J = 2'd2
    } instr_class_t;

    localparam logic [DEC_OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [DEC_OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [DEC_OPC_W-1:0] OPC_JAL   = 6'h03;

    // Opcodes the core implements; anything else is flagged, not dropped.
    localparam int N_LEGAL = 18;
    localparam logic [DEC_OPC_W-1:0] LEGAL_OPCODES [N_LEGAL] = '{
        6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
        6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h2B
    };

    typedef struct packed {
        logic [DEC_OPC_W-1:0]             opcode;
        logic [DEC_REG_W-1:0]             rs;
        logic [DEC_REG_W-1:0]             rt;
        logic [DEC_REG_W-1:0]             shamt;
        logic [DEC_FUNC_W-1:0]            func;
        logic [DEC_IMM_W-1:0]             imm;
        logic [DEC_INSTR_W-DEC_OPC_W-1:0] label2;
        logic [DEC_INSTR_W-1:0]           imm_sext;
        instr_class_t                     instr_class;
`ifdef DECODER_ILLEGAL_OP_EN
        logic                             illegal_op;
`endif
    } decoded_fields_t;

    function automatic instr_class_t classify(input logic [DEC_OPC_W-1:0] opcode);
        if (opcode == OPC_RTYPE) return CLS_R;
        if (opcode == OPC_J || opcode == OPC_JAL) return CLS_J;
        return CLS_I;
    endfunction

    function automatic logic is_legal_opcode(input logic [DEC_OPC_W-1:0] opcode);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL; i++) begin
            if (LEGAL_OPCODES[i] == opcode) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pipelined_instruction_decoder_if.sv
// Fetch-side and register-read-side handshake bundle of the decode stage.
// The decoder sits on the slave modport; fetch/consumer logic uses master.
interface pipelined_instruction_decoder_if
    import decoder_pkg::*;
#(
    parameter int INSTR_W = DEC_INSTR_W,
    parameter int OPC_W   = DEC_OPC_W,
    parameter int REG_W   = DEC_REG_W,
    parameter int FUNC_W  = DEC_FUNC_W,
    parameter int IMM_W   = DEC_IMM_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [INSTR_W-1:0]       in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPC_W-1:0]         opcode;
    logic [REG_W-1:0]         rs;
    logic [REG_W-1:0]         rt;
    logic [REG_W-1:0]         shamt;
    logic [FUNC_W-1:0]        func;
    logic [IMM_W-1:0]         imm;
    logic [IMM_W-1:0]         label1;
    logic [INSTR_W-OPC_W-1:0] label2;
    logic [INSTR_W-1:0]       imm_sext;
    logic [1:0]               instr_class;

`ifdef DECODER_ILLEGAL_OP_EN
    logic                     illegal_op;
    logic [15:0]              illegal_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, shamt, func, imm, label1,
               label2, imm_sext, instr_class, illegal_op, illegal_cnt
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, rs, rt, shamt, func, imm, label1,
               label2, imm_sext, instr_class, illegal_op, illegal_cnt
    );
`else
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, shamt, func, imm, label1,
               label2, imm_sext, instr_class
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, rs, rt, shamt, func, imm, label1,
               label2, imm_sext, instr_class
    );
`endif

endinterface

// File: rtl/pipelined_instruction_decoder_skid_buffer.sv
// Generic 2-entry valid/ready buffer (main + skid) with synchronous flush.
// in_ready is registered so no combinational path runs from out_ready to in_ready.
module decode_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t   state;
    buf_state_t   state_next;
    logic         ready_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_xfer;
    logic         out_xfer;
    logic         load_main_in;
    logic         load_skid_in;
    logic         load_main_skid;

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid & ready_q;
    assign out_xfer  = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) state_next = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_next = FULL;
                    else if (!in_xfer && out_xfer) state_next = EMPTY;
                end
                FULL:    if (out_xfer) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_main_in = in_xfer;
                ONE: begin
                    load_main_in = in_xfer && out_xfer;
                    load_skid_in = in_xfer && !out_xfer;
                end
                FULL:    load_main_skid = out_xfer;
                default: ;
            endcase
        end
    end

    // NOTE: payload registers are reset on purpose: the field outputs must read zero after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid_in)        skid_q <= in_data;
        end
    end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Registered decode stage between fetch and register read; decodes on the way in, stores fields.
// Optional DECODER_ILLEGAL_OP_EN adds illegal_op and a saturating illegal_cnt.
module pipelined_instruction_decoder
    import decoder_pkg::*;
#(
    parameter int INSTR_W = DEC_INSTR_W,
    parameter int OPC_W   = DEC_OPC_W,
    parameter int REG_W   = DEC_REG_W,
    parameter int FUNC_W  = DEC_FUNC_W,
    parameter int IMM_W   = DEC_IMM_W
) (
    input logic clk,
    input logic rst,
    input logic flush,
    pipelined_instruction_decoder_if.slave bus
);
    if (OPC_W + 3 * REG_W > INSTR_W) begin : g_bad_field_layout
        $error("opcode plus rs/rt/shamt fields do not fit in INSTR_W");
    end
    if (IMM_W > INSTR_W) begin : g_bad_imm_width
        $error("IMM_W exceeds INSTR_W");
    end
    // decoded_fields_t is sized in decoder_pkg, so a new geometry is made there.
    if (INSTR_W != DEC_INSTR_W || OPC_W != DEC_OPC_W || REG_W != DEC_REG_W ||
        FUNC_W != DEC_FUNC_W || IMM_W != DEC_IMM_W) begin : g_pkg_width_mismatch
        $error("parameters differ from the decoder_pkg field widths");
    end

    decoded_fields_t dec_in;
    decoded_fields_t dec_main;

    always_comb begin
        dec_in             = '0;
        dec_in.opcode      = bus.in_instr[INSTR_W-1 -: OPC_W];
        dec_in.rs          = bus.in_instr[INSTR_W-OPC_W-1 -: REG_W];
        dec_in.rt          = bus.in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
        dec_in.shamt       = bus.in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
        dec_in.func        = bus.in_instr[FUNC_W-1:0];
        dec_in.imm         = bus.in_instr[IMM_W-1:0];
        dec_in.label2      = bus.in_instr[INSTR_W-OPC_W-1:0];
        dec_in.imm_sext    = INSTR_W'($signed(bus.in_instr[IMM_W-1:0]));
        dec_in.instr_class = classify(bus.in_instr[INSTR_W-1 -: OPC_W]);
`ifdef DECODER_ILLEGAL_OP_EN
        dec_in.illegal_op  = ~is_legal_opcode(bus.in_instr[INSTR_W-1 -: OPC_W]);
`endif
    end

    decode_skid_buffer #(
        .W($bits(decoded_fields_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (dec_main)
    );

    assign bus.opcode      = dec_main.opcode;
    assign bus.rs          = dec_main.rs;
    assign bus.rt          = dec_main.rt;
    assign bus.shamt       = dec_main.shamt;
    assign bus.func        = dec_main.func;
    assign bus.imm         = dec_main.imm;
    assign bus.label1      = dec_main.imm;
    assign bus.label2      = dec_main.label2;
    assign bus.imm_sext    = dec_main.imm_sext;
    assign bus.instr_class = dec_main.instr_class;

`ifdef DECODER_ILLEGAL_OP_EN
    logic [15:0] illegal_cnt_q;

    // Counts at output transfer only, so flushed words never reach the count; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready && dec_main.illegal_op &&
                     illegal_cnt_q != 16'hFFFF) begin
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end

    assign bus.illegal_op  = dec_main.illegal_op;
    assign bus.illegal_cnt = illegal_cnt_q;
`endif

endmodule
